// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state codes and default parameters shared by the PLL reset controller.
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 1_000_000;
  localparam int DEF_QUAL_CYCLES  = 1024;
  localparam int DEF_MAX_RETRY    = 4;
  localparam int DEF_CNT_W        = 8;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// sync2: generic two-flop bit synchronizer with synchronous reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic r_meta, r_sync;
  always_ff @(posedge clk) begin
    if (rst) {r_sync, r_meta} <= 2'b00;
    else     {r_sync, r_meta} <= {r_meta, d};
  end
  assign q = r_sync;
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencer and lock supervisor.
// Defining PLL_RESET_CTRL_STATS_EN adds the saturating lol_count loss-of-lock counter.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int QUAL_CYCLES  = DEF_QUAL_CYCLES,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
`ifdef PLL_RESET_CTRL_STATS_EN
  , parameter int CNT_W      = DEF_CNT_W
`endif
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             relock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state
`ifdef PLL_RESET_CTRL_STATS_EN
  , output logic [CNT_W-1:0] lol_count
`endif
);
  localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, QUAL_CYCLES)) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  pll_state_e    r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry, w_retry;
  logic          w_lock_s, w_tclr, w_loss;
  logic          r_pll_rst, r_sys_rst, r_ready, r_fault;

  sync2 u_sync (.clk(refclk), .rst(rst), .d(locked), .q(w_lock_s));

  assign w_loss = (r_state == RUN) && !w_lock_s;

  always_comb begin
    w_next  = r_state;
    w_retry = r_retry;
    if (relock) begin
      w_next  = RST_PLL;
      w_retry = (r_state == FAULT) ? '0 : r_retry;
    end else begin
      case (r_state)
        RST_PLL:   w_next = (r_timer == TW'(RST_CYCLES - 1)) ? WAIT_LOCK : RST_PLL;
        WAIT_LOCK: begin
          if (w_lock_s) w_next = QUALIFY;
          else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
            w_retry = r_retry + 1'b1;
            w_next  = (w_retry == RW'(MAX_RETRY)) ? FAULT : RST_PLL;
          end
        end
        QUALIFY: begin
          if (!w_lock_s) w_next = WAIT_LOCK;
          else if (r_timer == TW'(QUAL_CYCLES - 1)) begin
            w_next  = RUN;
            w_retry = '0;
          end
        end
        RUN:     w_next = w_lock_s ? RUN : RST_PLL;
        FAULT:   w_next = FAULT;
        default: w_next = RST_PLL;
      endcase
    end
    w_tclr = relock || (w_next != r_state);
  end

  // timer only advances in the bounded states, so it can never wrap in RUN/FAULT
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= RST_PLL;
      r_timer   <= '0;
      r_retry   <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_tclr ? '0 : (r_state < RUN) ? r_timer + 1'b1 : r_timer;
      r_retry   <= w_retry;
      r_pll_rst <= (w_next == RST_PLL) || (w_next == FAULT);
      r_sys_rst <= (w_next != RUN);
      r_ready   <= (w_next == RUN);
      r_fault   <= (w_next == FAULT);
    end
  end

`ifdef PLL_RESET_CTRL_STATS_EN
  logic [CNT_W-1:0] r_lol;
  always_ff @(posedge refclk) begin
    if (rst) r_lol <= '0;
    else if (w_loss && !(&r_lol)) r_lol <= r_lol + 1'b1;
  end
  assign lol_count = r_lol;
`else
  logic w_loss_unused;
  assign w_loss_unused = w_loss;
`endif

  assign pll_rst = r_pll_rst;
  assign sys_rst = r_sys_rst;
  assign ready   = r_ready;
  assign fault   = r_fault;
  assign state   = r_state;
endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer and lock supervisor for the measurement PLL. It drives the PLL's `rst` input and consumes the PLL's asynchronous `locked` output. It qualifies lock, releases a synchronous system reset to downstream counting logic only after lock has been stable, and re-sequences the PLL on loss of lock, timeout or request. It runs in the reference clock domain, the same clock that feeds the PLL, and sits between board reset and the frequency-meter core.

## Interface
- `RST_CYCLES`, default 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_TIMEOUT`, default 1_000_000: cycles allowed in WAIT_LOCK before retry.
- `QUAL_CYCLES`, default 1024: consecutive synchronized-lock cycles required before RUN.
- `MAX_RETRY`, default 4: consecutive timeouts tolerated before FAULT (≥1).
- `CNT_W`, default 8: width of the loss-of-lock counter.

Ports:
- `refclk` in 1: single clock, PLL reference clock.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `relock` in 1: single-cycle request to re-sequence the PLL.
- `pll_rst` out 1: reset to the PLL.
- `sys_rst` out 1: synchronous active-high reset for downstream logic.
- `ready` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `state` out 3: current FSM state code.
- `lol_count` out CNT_W: loss-of-lock event count (present only with the stats macro).

## Operation
- `locked` passes through a 2-flop synchronizer to produce `lock_s`. No other logic uses raw `locked`.
- States and codes: RST_PLL=0, WAIT_LOCK=1, QUALIFY=2, RUN=3, FAULT=4. All outputs are registered and change in the same cycle as `state`.
- RST_PLL: `pll_rst`=1 and `sys_rst`=1. The timer counts RST_CYCLES cycles, then the FSM moves to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: `pll_rst`=0 and `sys_rst`=1.
  - `lock_s`=1: go to QUALIFY with the timer cleared.
  - Timer reaches LOCK_TIMEOUT: `retry_cnt` increments. If it equals MAX_RETRY, go to FAULT. Otherwise go to RST_PLL.
- QUALIFY: `pll_rst`=0 and `sys_rst`=1.
  - `lock_s`=0: return to WAIT_LOCK. The timer clears and the timeout window restarts.
  - QUAL_CYCLES consecutive high samples: go to RUN and clear `retry_cnt`.
- RUN: `sys_rst`=0 and `ready`=1. On `lock_s`=0, go to RST_PLL; with the stats macro, `lol_count` increments and saturates at all-ones.
- FAULT: `pll_rst`=1, `sys_rst`=1, `fault`=1. Leaves only on `rst`, or on `relock`, which clears `retry_cnt` and goes to RST_PLL.
- `relock` in any state goes to RST_PLL with the timer cleared. `retry_cnt` is unchanged except when leaving FAULT.
- `relock` together with lock loss in RUN: go to RST_PLL, and the loss is still counted.
- Timer width is $clog2 of the largest of the three cycle parameters, plus 1. The timer never wraps: it is cleared on every state change.

## Timing
- Reset values: `state`=RST_PLL, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `lol_count`=0, timer=0, `retry_cnt`=0.
- `rst` mid-operation: on the next edge all registers return to their reset values. The synchronizer flops reset to 0.
- The first cycle after `rst` falls is RST_PLL cycle 1. `pll_rst` falls after exactly RST_CYCLES cycles.
- `locked` rising to QUALIFY entry takes 3 edges: 2 synchronizer stages plus 1 FSM edge.
- QUALIFY entry to `ready`=1 takes QUAL_CYCLES edges.
- `locked` falling in RUN to `sys_rst`=1 takes 3 edges.

## Configuration
- `PLL_RESET_CTRL_STATS_EN` defined: the `lol_count` port and its saturating counter exist. The counter clears only on `rst`.
- Undefined: the port and counter are absent. FSM behaviour is identical.

## Structure
- Shared package `pll_ctrl_pkg` holds:
  - the state enum typedef and the 3-bit state codes;
  - the default parameter constants.
- One sub-module, `sync2`: a generic 2-flop bit synchronizer with synchronous reset, reused by other clock-crossing points in the meter.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, QUAL_CYCLES=8, MAX_RETRY=2.
- Nominal lock: release `rst`, raise `locked` at cycle 10 → `pll_rst` falls at cycle 4, QUALIFY at cycle 13, `ready`=1 and `sys_rst`=0 at cycle 21.
- Qualify glitch: `locked` goes low for 1 cycle during QUALIFY → return to WAIT_LOCK, and `ready` is delayed by a full 8 qualified cycles after relock.
- Timeouts: `locked` held at 0 → two RST_PLL/WAIT_LOCK attempts, then FAULT with `fault`=1 and `pll_rst`=1. `relock` then gives RST_PLL, `fault`=0.
- Loss in RUN: drop `locked` → `sys_rst`=1 three edges later, `lol_count` goes 0→1. Stats build checks saturation at 255 after 300 losses.
- `relock` in RUN, same cycle as lock loss → RST_PLL, `lol_count` +1, `ready`=0 next edge.
- `rst` asserted in QUALIFY → next edge shows all reset values, `state`=0.
